// File: rtl/itof_pkg.sv
// Shared FPU constants and helpers for the int-to-float converter.
// Field widths follow IEEE-754 single precision.
package itof_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;

    // Exponent of a value whose leading one sits at bit 31 (127 + 31).
    localparam logic [EXP_W-1:0] ITOF_EXP_BASE = 8'd158;

    // Round-to-nearest, ties-to-even increment decision.
    function automatic logic rne_round_up(input logic guard, input logic sticky, input logic lsb);
        return guard & (sticky | lsb);
    endfunction

endpackage

// File: rtl/itof_lzc32.sv
// Combinational 32-bit leading-zero counter; reports 32 for an all-zero input.
module lzc32 (
    input  logic [31:0] a,
    output logic [5:0]  lz
);

    // Scan upward so the highest set bit is the last one to update the count.
    always_comb begin
        lz = 6'd32;
        for (int i = 0; i < 32; i++) begin
            lz = a[i] ? 6'(31 - i) : lz;
        end
    end

endmodule

// File: rtl/itof.sv
// Two-stage signed 32-bit integer to float32 converter, round-to-nearest-even.
// Stage 1 takes magnitude and leading-zero count; stage 2 normalises and rounds.
module itof
    import itof_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x,
    input  logic        x_valid,
    output logic [31:0] y,
    output logic        y_valid
);

    logic [31:0]      mag_s;
    logic [5:0]       lz_s;

    logic             sign_r;
    logic [31:0]      mag_r;
    logic [5:0]       lz_r;
    logic             zero_r;
    logic             v1_r;

    logic [31:0]      norm_s;
    logic [MAN_W-1:0] man_s;
    logic             guard_s;
    logic             sticky_s;
    logic [MAN_W:0]   man_rnd_s;
    logic [EXP_W-1:0] exp_s;
    logic [EXP_W-1:0] exp_fin_s;
    logic [MAN_W-1:0] man_fin_s;
    logic [31:0]      y_nxt_s;

    // Two's-complement magnitude; -2^31 wraps to 0x80000000 as wanted.
    always_comb begin
        if (x[31]) begin
            mag_s = ~x + 32'd1;
        end else begin
            mag_s = x;
        end
    end

    lzc32 u_lzc (
        .a  (mag_s),
        .lz (lz_s)
    );

    // Stage 1 register: sign, magnitude, leading-zero count, zero flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sign_r <= 1'b0;
            mag_r  <= 32'd0;
            lz_r   <= 6'd0;
            zero_r <= 1'b1;
            v1_r   <= 1'b0;
        end else begin
            sign_r <= x[31];
            mag_r  <= mag_s;
            lz_r   <= lz_s;
            zero_r <= (x == 32'd0);
            v1_r   <= x_valid;
        end
    end

    // Normalise, round to nearest even, and fold a mantissa carry into the exponent.
    always_comb begin
        norm_s    = mag_r << lz_r;
        man_s     = norm_s[30:8];
        guard_s   = norm_s[7];
        sticky_s  = |norm_s[6:0];
        man_rnd_s = {1'b0, man_s} + {23'd0, rne_round_up(guard_s, sticky_s, man_s[0])};
        exp_s     = ITOF_EXP_BASE - {2'b00, lz_r};
        if (man_rnd_s[MAN_W]) begin
            exp_fin_s = exp_s + 8'd1;
            man_fin_s = 23'd0;
        end else begin
            exp_fin_s = exp_s;
            man_fin_s = man_rnd_s[MAN_W-1:0];
        end
        if (zero_r) begin
            y_nxt_s = 32'd0;
        end else begin
            y_nxt_s = {sign_r, exp_fin_s, man_fin_s};
        end
    end

    // Output register; data advances every cycle, only y_valid is qualified.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            y       <= 32'd0;
            y_valid <= 1'b0;
        end else begin
            y       <= y_nxt_s;
            y_valid <= v1_r;
        end
    end

endmodule

// File: tb/tb_itof.sv
// Randomised scoreboard bench for itof against an arithmetic float32 reference.
module tb_itof;

    logic        clk;
    logic        rstn;
    logic [31:0] x;
    logic        x_valid;
    logic [31:0] y;
    logic        y_valid;

    typedef struct {
        logic [31:0] val;
        logic [31:0] xin;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   checks;
    int   errors;

    itof dut (
        .clk     (clk),
        .rstn    (rstn),
        .x       (x),
        .x_valid (x_valid),
        .y       (y),
        .y_valid (y_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer magnitude, rounded with plain arithmetic.
    function automatic logic [31:0] ref_itof(input logic [31:0] xi);
        logic [63:0] m, qv, rem, half;
        int          e, sh;
        logic        s;
        if (xi == 32'd0) return 32'd0;
        s = xi[31];
        m = s ? (64'd4294967296 - {32'd0, xi}) : {32'd0, xi};
        e = 0;
        for (int i = 0; i < 33; i++) if (m >= (64'd1 << i)) e = i;
        if (e <= 23) begin
            qv = m << (23 - e);
        end else begin
            sh   = e - 23;
            qv   = m >> sh;
            rem  = m - (qv << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && qv[0])) qv = qv + 64'd1;
            if (qv == (64'd1 << 24)) begin
                qv = qv >> 1;
                e  = e + 1;
            end
        end
        return {s, 8'(e + 127), qv[22:0]};
    endfunction

    // Monitor: pops expectations when y_valid shows, flags strays and misses.
    always begin
        exp_t e;
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        if (y_valid) begin
            checks = checks + 1;
            if (q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_valid cyc=%0d y=%08h expected no output", cyc, y);
            end else begin
                e = q.pop_front();
                if (e.due != cyc || y !== e.val) begin
                    errors = errors + 1;
                    $display("FAIL result x=%08h got y=%08h at cyc %0d, expected %08h at cyc %0d",
                             e.xin, y, cyc, e.val, e.due);
                end
            end
        end
        while (q.size() > 0 && q[0].due < cyc) begin
            e = q.pop_front();
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL missing_valid x=%08h expected %08h at cyc %0d, y_valid stayed low", e.xin, e.val, e.due);
        end
    end

    task automatic drive(input logic [31:0] xi, input logic v, input logic [31:0] expv);
        exp_t e;
        @(negedge clk);
        x       = xi;
        x_valid = v;
        if (v) begin
            e.val = expv;
            e.xin = xi;
            e.due = cyc + 2;
            q.push_back(e);
        end
    endtask

    task automatic drive_rand(input logic [31:0] xi, input logic v);
        drive(xi, v, ref_itof(xi));
    endtask

    task automatic check_reset_outputs(input string tag);
        checks = checks + 1;
        if (y !== 32'd0 || y_valid !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL %s got y=%08h y_valid=%0b, expected y=00000000 y_valid=0", tag, y, y_valid);
        end
    endtask

    function automatic logic [31:0] rand_x();
        logic [31:0] r;
        int          mode;
        r    = $urandom;
        mode = $urandom_range(0, 3);
        case (mode)
            0:       rand_x = r;
            1:       rand_x = r >> $urandom_range(0, 31);
            2:       rand_x = 32'd16777216 + (r & 32'h0000_00FF);
            default: rand_x = 32'd0 - (r >> $urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        cyc     = 0;
        checks  = 0;
        errors  = 0;
        rstn    = 1'b0;
        x       = 32'd0;
        x_valid = 1'b0;
        #12;
        check_reset_outputs("reset_state");
        @(negedge clk);
        rstn = 1'b1;

        // Directed values with constants taken straight from IEEE-754 encodings.
        drive(32'd1,         1'b1, 32'h3F80_0000);
        drive(32'hFFFF_FFFF, 1'b1, 32'hBF80_0000);
        drive(32'd0,         1'b1, 32'h0000_0000);
        drive(32'd5,         1'b0, 32'h0000_0000);
        drive(32'h7FFF_FFFF, 1'b1, 32'h4F00_0000);
        drive(32'h8000_0000, 1'b1, 32'hCF00_0000);
        drive(32'd16777217,  1'b1, 32'h4B80_0000);
        drive(32'd16777219,  1'b1, 32'h4B80_0002);
        drive(32'd16777218,  1'b1, 32'h4B80_0001);
        drive(32'd16777215,  1'b1, 32'h4B7F_FFFF);

        for (int i = 0; i < 3000; i++) drive_rand(rand_x(), 1'($urandom_range(0, 3) != 0));

        // Flush: one operand registered, one on the input, then reset for a cycle.
        drive_rand(32'd1234567, 1'b1);
        drive_rand(32'd7654321, 1'b1);
        @(negedge clk);
        rstn    = 1'b0;
        x_valid = 1'b0;
        while (q.size() > 0 && q[q.size()-1].due > cyc) void'(q.pop_back());
        #1;
        check_reset_outputs("reset_flush");
        @(negedge clk);
        check_reset_outputs("reset_hold");
        rstn = 1'b1;
        drive(32'd2, 1'b0, 32'h0000_0000);
        drive(32'd2, 1'b1, 32'h4000_0000);

        for (int i = 0; i < 3000; i++) drive_rand(rand_x(), 1'($urandom_range(0, 1) != 0));

        drive(32'd0, 1'b0, 32'h0000_0000);
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        checks = checks + 1;
        if (q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain pending=%0d expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/itof.md
ITOF -- requirements
Module: itof

Interface
REQ-001 Parameters: none; latency is fixed at 2 cycles.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rstn  input  1  reset; asynchronous, active-low; one clock, asynchronous active-low reset (fixed).
REQ-004 x  input  32  signed two's-complement integer operand.
REQ-005 x_valid  input  1  x is meaningful this cycle.
REQ-006 y  output  32  IEEE-754 single-precision result {sign, exp[7:0], man[22:0]}, registered.
REQ-007 y_valid  output  1  y carries the result of the x sampled 2 cycles earlier.

Function
REQ-008 The block SHALL convert x to the nearest float32 using round-to-nearest, ties-to-even.
REQ-009 The pipeline SHALL accept a new x every cycle, with no back-pressure and no stall input.
REQ-010 Latency SHALL be exactly 2 rising edges from x/x_valid sampled to y/y_valid valid; y_valid SHALL be x_valid delayed 2 cycles.
REQ-011 Stage 1 (x sampled -> register): sign = x[31]; magnitude = |x| as a 32-bit unsigned value, with -2^31 giving 0x80000000; lz = leading-zero count of magnitude (0..32); zero flag.
REQ-012 Stage 2 (register -> y register): normalize magnitude left by lz; mantissa = bits [30:8]; guard = bit 7; sticky = OR of bits [6:0]; round up when guard & (sticky | mantissa LSB).
REQ-013 Exponent SHALL be 158 - lz (8-bit); a rounding carry out of the mantissa SHALL increment the exponent and zero the mantissa.
REQ-014 x = 0 SHALL produce y = 0x00000000 (+0, never -0).
REQ-015 Magnitudes below 2^24 SHALL convert exactly, with guard and sticky both 0.
REQ-016 The output SHALL never be denormal, infinite or NaN; the maximum exponent is 158.
REQ-017 When x_valid = 0, the datapath MAY still advance, but y_valid SHALL be 0 for that slot; y content is don't-care when y_valid = 0.
REQ-018 Data registers SHALL capture every cycle regardless of x_valid; only y_valid carries qualification.

Reset
REQ-019 While rstn = 0, all pipeline registers SHALL clear asynchronously: y = 0x00000000 and y_valid = 0.
REQ-020 Reset asserted mid-operation SHALL discard all in-flight operands; no stale y_valid pulse SHALL appear after release.
REQ-021 After rstn deasserts, the first y_valid SHALL appear 2 cycles after the first sampled x_valid = 1.

Structure
REQ-022 A shared FPU package SHALL hold the constants: EXP_BIAS = 127, EXP_W = 8, MAN_W = 23, and the int-to-float exponent base 158.
REQ-023 One sub-module SHALL be used: lzc32 (combinational 32-bit leading-zero counter, 6-bit output, 32 for all-zero input), instantiated in stage 1.
REQ-024 All other logic SHALL be inline; no inferred latches and no combinational path from x to y.

Verification
REQ-025 Sweep 1, -1, 0, then x_valid = 0 -> y = 0x3F800000, 0xBF800000, 0x00000000 on consecutive cycles, each 2 cycles after its input; y_valid = 1,1,1,0.
REQ-026 Extremes 0x7FFFFFFF and 0x80000000 -> 0x4F000000 (rounding carry into exponent) and 0xCF000000.
REQ-027 Ties 16777217 and 16777219 -> 0x4B800000 (tie, round down to even) and 0x4B800002 (tie, round up to even); 16777218 -> 0x4B800001 exact.
REQ-028 Back-to-back stream of 10^6 random x with random x_valid -> every y_valid result bit-exact against a reference model with ties-to-even, in order, at latency 2.
REQ-029 Assert rstn low for 1 cycle while two valid operands are in flight -> y = 0 and y_valid = 0 immediately, no valid output for the flushed operands, and normal operation on the next valid input.
